bus_slave_responder: RTL and testbench

BUS_SLAVE_RESPONDER -- requirements
Module: bus_slave_responder

---
 rtl/bus_slave_responder.sv | 129 ++++++++++++
 tb/tb_bus_slave_responder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bus_slave_responder.sv
// Register-file bus slave: single outstanding request, latched at acceptance, answered after a fixed wait.
// Latency: strobe at edge k -> ack/rvalid/err pulse for the cycle after edge k+wait_cycles+1.
// Backpressure: none; strobes seen while busy (or in the response cycle) are dropped, no queueing.
`timescale 1ns/1ps
module bus_slave_responder #(
    parameter int address_length = 11,
    parameter int data_length    = 31,
    parameter int mem_depth_log2 = 4,
    parameter int wait_cycles    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [address_length:0] address_slave,
    input  logic [data_length:0]    data,
    input  logic                    wen,
    input  logic                    ren,
    output logic [data_length:0]    rdata,
    output logic                    rvalid,
    output logic                    ack,
    output logic                    err,
    output logic                    busy
);
    localparam int DEPTH = 1 << mem_depth_log2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic [address_length:0] addr_q;
    logic [data_length:0]    data_q;
    logic                    op_wr;
    logic                    op_rd;
    logic                    err_q;
    logic [data_length:0]    mem [DEPTH];

    // The access happens on the edge entering RESP; with no wait states that is
    // the acceptance edge itself, so the live bus is used instead of the latches.
    logic [address_length:0]   acc_addr;
    logic [data_length:0]      acc_data;
    logic                      acc_wr;
    logic                      acc_rd;
    logic                      acc_in_range;
    logic [mem_depth_log2-1:0] acc_idx;

    always_comb begin
        acc_addr     = (state == IDLE) ? address_slave : addr_q;
        acc_data     = (state == IDLE) ? data          : data_q;
        acc_wr       = (state == IDLE) ? wen           : op_wr;
        acc_rd       = (state == IDLE) ? ren           : op_rd;
        acc_in_range = ((acc_addr >> mem_depth_log2) == '0);
        acc_idx      = acc_addr[mem_depth_log2-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            data_q <= '0;
            op_wr  <= 1'b0;
            op_rd  <= 1'b0;
            err_q  <= 1'b0;
            rdata  <= '0;
            rvalid <= 1'b0;
            ack    <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            ack    <= 1'b0;
            rvalid <= 1'b0;
            err    <= 1'b0;

            // Commit: memory and rdata update on the edge that enters RESP.
            if ((state == IDLE && (wen || ren) && wait_cycles == 0) ||
                (state == WAIT && cnt == '0)) begin
                if (acc_wr && acc_rd) begin
                    err_q <= 1'b1;
                end else if (acc_wr) begin
                    err_q <= !acc_in_range;
                    if (acc_in_range) begin
                        mem[acc_idx] <= acc_data;
                    end
                end else begin
                    err_q <= !acc_in_range;
                    rdata <= acc_in_range ? mem[acc_idx] : '0;
                end
            end

            case (state)
                IDLE: begin
                    if (wen || ren) begin
                        addr_q <= address_slave;
                        data_q <= data;
                        op_wr  <= wen;
                        op_rd  <= ren;
                        busy   <= 1'b1;
                        if (wait_cycles > 0) begin
                            state <= WAIT;
                            cnt   <= 4'(wait_cycles - 1);
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    ack    <= op_wr;
                    rvalid <= op_rd && !op_wr;
                    err    <= err_q;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_slave_responder.sv
// Directed bench for bus_slave_responder with wait_cycles=2.
// Latency: each request is checked exactly at edge k+3, with silence at k+2.
// Backpressure: overlapping strobes and mid-transaction reset are exercised directly.
`timescale 1ns/1ps
module tb_bus_slave_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] address_slave = '0;
    logic [31:0] data = '0;
    logic        wen = 1'b0;
    logic        ren = 1'b0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        ack;
    logic        err;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int n_ack;

    bus_slave_responder #(
        .address_length(11),
        .data_length   (31),
        .mem_depth_log2(4),
        .wait_cycles   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .address_slave(address_slave),
        .data         (data),
        .wen          (wen),
        .ren          (ren),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .ack          (ack),
        .err          (err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Presents one request at edge k, checks silence at k+2, returns with outputs sampled after k+3.
    task automatic req(input string tag, input logic w, input logic r,
                       input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        rst = 1'b1;
        wen = w;
        ren = r;
        address_slave = a;
        data = d;
        @(posedge clk);
        @(negedge clk);
        wen = 1'b0;
        ren = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk({tag, "_early"}, 32'({ack, rvalid}), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #50;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_flags", 32'({rvalid, ack, err, busy}), 32'd0);

        req("rd3_init", 1'b0, 1'b1, 12'h003, 32'h0);
        chk("rd3_init_rvalid", 32'(rvalid), 32'd1);
        chk("rd3_init_ack_err", 32'({ack, err}), 32'd0);
        chk("rd3_init_rdata", rdata, 32'h0);

        req("wr3", 1'b1, 1'b0, 12'h003, 32'h1010_1010);
        chk("wr3_ack_err_rv", 32'({ack, err, rvalid}), 32'b100);
        chk("wr3_rdata_hold", rdata, 32'h0);
        req("rd3", 1'b0, 1'b1, 12'h003, 32'h0);
        chk("rd3_rvalid_err", 32'({rvalid, err}), 32'b10);
        chk("rd3_rdata", rdata, 32'h1010_1010);
        @(posedge clk);
        #1;
        chk("rd3_pulse_one_cycle", 32'({rvalid, ack}), 32'd0);
        chk("rd3_rdata_hold", rdata, 32'h1010_1010);

        req("wr_oor", 1'b1, 1'b0, 12'h100, 32'h0101_0101);
        chk("wr_oor_ack_err", 32'({ack, err, rvalid}), 32'b110);
        req("rd0", 1'b0, 1'b1, 12'h000, 32'h0);
        chk("rd0_rvalid_err", 32'({rvalid, err}), 32'b10);
        chk("rd0_rdata", rdata, 32'h0);

        req("rd3b", 1'b0, 1'b1, 12'h003, 32'h0);
        chk("rd3b_rdata", rdata, 32'h1010_1010);
        req("rd_oor", 1'b0, 1'b1, 12'h010, 32'h0);
        chk("rd_oor_rvalid_err", 32'({rvalid, err, ack}), 32'b110);
        chk("rd_oor_rdata", rdata, 32'h0);

        req("rd3c", 1'b0, 1'b1, 12'h003, 32'h0);
        req("both", 1'b1, 1'b1, 12'h001, 32'hFFFF_FFFE);
        chk("both_flags", 32'({ack, err, rvalid}), 32'b110);
        chk("both_rdata_hold", rdata, 32'h1010_1010);
        req("rd1_after_both", 1'b0, 1'b1, 12'h001, 32'h0);
        chk("rd1_after_both_rdata", rdata, 32'h0);

        // Second write arrives while busy and must be dropped.
        @(negedge clk);
        wen = 1'b1;
        address_slave = 12'h001;
        data = 32'h1111_1111;
        @(posedge clk);
        @(negedge clk);
        address_slave = 12'h002;
        data = 32'h2222_2222;
        @(posedge clk);
        @(negedge clk);
        wen = 1'b0;
        n_ack = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (ack) n_ack++;
        end
        chk("b2b_ack_count", 32'(n_ack), 32'd1);
        req("rd1", 1'b0, 1'b1, 12'h001, 32'h0);
        chk("rd1_rdata", rdata, 32'h1111_1111);
        req("rd2", 1'b0, 1'b1, 12'h002, 32'h0);
        chk("rd2_rdata", rdata, 32'h0);

        // Reset during WAIT aborts the write.
        req("rd1_pre", 1'b0, 1'b1, 12'h001, 32'h0);
        @(negedge clk);
        wen = 1'b1;
        address_slave = 12'h004;
        data = 32'h0000_0001;
        @(posedge clk);
        @(negedge clk);
        wen = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rdata", rdata, 32'h0);
        n_ack = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (ack || rvalid) n_ack++;
        end
        chk("abort_no_resp", 32'(n_ack), 32'd0);
        // req releases reset on the same negedge, so the first edge after reset accepts.
        req("rd4", 1'b0, 1'b1, 12'h004, 32'h0);
        chk("rd4_rvalid", 32'(rvalid), 32'd1);
        chk("rd4_rdata", rdata, 32'h0);
        req("rd1_post", 1'b0, 1'b1, 12'h001, 32'h0);
        chk("rd1_post_rdata", rdata, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
